// File: rtl/nn_param_loader.sv
// Purpose : streams the 1->N->N->1 MLP parameter set into the nn weight/bias register files.
// Latency : an accepted word is written one cycle later; done follows the last write by one cycle.
// Backpressure: s_ready is high only while loading (and while waiting for the checksum word).
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   start, abort          begin a load (IDLE only) / terminate the load in progress
//   s_valid/s_ready/s_data  16-bit parameter word stream
//   wr_en/wr_sel/wr_row/wr_col/wr_data  single-word register write port towards nn
//   busy, done, err       load in progress, completion pulse, sticky checksum error
//
// Build option: define NN_LOAD_CHECKSUM_EN to expect one extra checksum word after the
// parameter words (mod-2^DATA_W sum of all words). Without it err is tied 0.
// Word order: l1weights(N), l1bias(N), l2weights(N*N, column fastest), l2bias(N),
// l3weights(N), outbias(1).
module nn_param_loader #(
   parameter int N      = 16,
   parameter int DATA_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  s_valid,
   input  logic [DATA_W-1:0]     s_data,
   output logic                  s_ready,
   output logic                  wr_en,
   output logic [2:0]            wr_sel,
   output logic [$clog2(N)-1:0]  wr_row,
   output logic [$clog2(N)-1:0]  wr_col,
   output logic [DATA_W-1:0]     wr_data,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int              IW      = $clog2(N);
   localparam logic [IW-1:0]   IDX_MAX = IW'(N - 1);

   // S_FLUSH covers the cycle in which the last word is being written, so that
   // done lands one cycle after the final wr_en.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_FLUSH = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          sel_q, sel_d;
   logic [IW-1:0]       row_q, row_d;
   logic [IW-1:0]       col_q, col_d;
   logic                wr_en_q, wr_en_d;
   logic [2:0]          wr_sel_q, wr_sel_d;
   logic [IW-1:0]       wr_row_q, wr_row_d;
   logic [IW-1:0]       wr_col_q, wr_col_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
`ifdef NN_LOAD_CHECKSUM_EN
   logic [DATA_W-1:0]   sum_q, sum_d;
   logic                err_q, err_d;
`endif

   logic                accept;
   logic                last_row;
   logic                last_col;
   logic                last_word;

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      row_d     = row_q;
      col_d     = col_q;
      wr_en_d   = 1'b0;
      wr_sel_d  = wr_sel_q;
      wr_row_d  = wr_row_q;
      wr_col_d  = wr_col_q;
      wr_data_d = wr_data_q;
`ifdef NN_LOAD_CHECKSUM_EN
      sum_d     = sum_q;
      err_d     = err_q;
`endif

      // abort suppresses acceptance of a beat presented in the same cycle
      s_ready   = ((state_q == S_LOAD) || (state_q == S_CHECK)) && !abort;
      accept    = s_valid && s_ready;
      last_row  = (row_q == IDX_MAX);
      last_col  = (col_q == IDX_MAX);
      last_word = (sel_q == 3'd5);

      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d = S_LOAD;
               sel_d   = 3'd0;
               row_d   = '0;
               col_d   = '0;
`ifdef NN_LOAD_CHECKSUM_EN
               sum_d   = '0;
               err_d   = 1'b0;
`endif
            end
         end

         S_LOAD: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (accept) begin
               wr_en_d   = 1'b1;
               wr_sel_d  = sel_q;
               wr_row_d  = row_q;
               wr_col_d  = col_q;
               wr_data_d = s_data;
`ifdef NN_LOAD_CHECKSUM_EN
               sum_d     = sum_q + s_data;
`endif
               // Per-section row/col counters; both are 0 on entry to a section,
               // so they map straight onto wr_row/wr_col.
               case (sel_q)
                  3'd0, 3'd1, 3'd3: begin
                     row_d = row_q + 1'b1;
                     if (last_row) begin
                        row_d = '0;
                        sel_d = sel_q + 3'd1;
                     end
                  end
                  3'd2: begin
                     col_d = col_q + 1'b1;
                     if (last_col) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                        if (last_row) begin
                           row_d = '0;
                           sel_d = 3'd3;
                        end
                     end
                  end
                  3'd4: begin
                     col_d = col_q + 1'b1;
                     if (last_col) begin
                        col_d = '0;
                        sel_d = 3'd5;
                     end
                  end
                  default: begin
                     sel_d = sel_q;
                  end
               endcase
               if (last_word) begin
`ifdef NN_LOAD_CHECKSUM_EN
                  state_d = S_CHECK;
`else
                  state_d = S_FLUSH;
`endif
               end
            end
         end

         S_FLUSH: begin
            state_d = abort ? S_IDLE : S_DONE;
         end

         S_CHECK: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (accept) begin
`ifdef NN_LOAD_CHECKSUM_EN
               err_d   = (s_data != sum_q);
`endif
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         sel_q     <= 3'd0;
         row_q     <= '0;
         col_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_sel_q  <= 3'd0;
         wr_row_q  <= '0;
         wr_col_q  <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef NN_LOAD_CHECKSUM_EN
         sum_q     <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         row_q     <= row_d;
         col_q     <= col_d;
         wr_en_q   <= wr_en_d;
         wr_sel_q  <= wr_sel_d;
         wr_row_q  <= wr_row_d;
         wr_col_q  <= wr_col_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef NN_LOAD_CHECKSUM_EN
         sum_q     <= sum_d;
         err_q     <= err_d;
`endif
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_sel  = wr_sel_q;
   assign wr_row  = wr_row_q;
   assign wr_col  = wr_col_q;
   assign wr_data = wr_data_q;
   assign busy    = busy_q;
   assign done    = done_q;
`ifdef NN_LOAD_CHECKSUM_EN
   assign err     = err_q;
`else
   assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_nn_param_loader.sv
module tb_nn_param_loader;

   localparam int N  = 16;
   localparam int DW = 16;
   localparam int W  = N * N + 4 * N + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          abort;
   logic          s_valid;
   logic [DW-1:0] s_data;
   logic          s_ready;
   logic          wr_en;
   logic [2:0]    wr_sel;
   logic [3:0]    wr_row;
   logic [3:0]    wr_col;
   logic [DW-1:0] wr_data;
   logic          busy;
   logic          done;
   logic          err;

   nn_param_loader #(.N(N), .DATA_W(DW)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .abort   (abort),
      .s_valid (s_valid),
      .s_data  (s_data),
      .s_ready (s_ready),
      .wr_en   (wr_en),
      .wr_sel  (wr_sel),
      .wr_row  (wr_row),
      .wr_col  (wr_col),
      .wr_data (wr_data),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // write/done monitor, sampled on the falling edge
   int cyc = 0;
   int wr_n = 0;
   int done_n = 0;
   int done_cyc = 0;
   int log_sel [0:511];
   int log_row [0:511];
   int log_col [0:511];
   int log_dat [0:511];
   int log_cyc [0:511];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (wr_en && wr_n < 512) begin
         log_sel[wr_n] = int'(wr_sel);
         log_row[wr_n] = int'(wr_row);
         log_col[wr_n] = int'(wr_col);
         log_dat[wr_n] = int'(wr_data);
         log_cyc[wr_n] = cyc;
         wr_n++;
      end
      if (done) begin
         done_n++;
         done_cyc = cyc;
      end
   end

   // Reference index map written directly from the word-order definition.
   function automatic void exp_idx(input int k, output int sel, output int row, output int col);
      sel = 5; row = 0; col = 0;
      if (k < N) begin
         sel = 0; row = k;
      end else if (k < 2 * N) begin
         sel = 1; row = k - N;
      end else if (k < 2 * N + N * N) begin
         sel = 2; row = (k - 2 * N) / N; col = (k - 2 * N) % N;
      end else if (k < 3 * N + N * N) begin
         sel = 3; row = k - 2 * N - N * N;
      end else if (k < 4 * N + N * N) begin
         sel = 4; col = k - 3 * N - N * N;
      end
   endfunction

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Offers words 0..W-1 in order. Returns at a falling edge with inputs idle,
   // except on the reset path where it returns just after asserting rst.
   task automatic feed(input bit gaps, input int abort_k, input int start_k, input int rst_k,
                       output int k);
      int budget;
      bit acc;
      bit ab;
      k = 0;
      budget = 0;
      ab = 1'b0;
      while (k < W && budget < 3000) begin
         @(negedge clk);
         if (k == rst_k) begin
            s_valid = 1'b0;
            start = 1'b0;
            abort = 1'b0;
            #2 rst = 1'b1;
            return;
         end
         s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         s_data  = 16'(k);
         abort   = (k == abort_k) && s_valid;
         start   = (k == start_k) && s_valid;
         #1 acc = s_valid && s_ready;
         @(posedge clk);
         budget++;
         if (abort) begin
            ab = 1'b1;
            break;
         end
         if (acc) k++;
      end
      @(negedge clk);
      s_valid = 1'b0;
      abort = 1'b0;
      start = 1'b0;
      checks++;
      if (!ab && k != W) begin
         errors++;
         $display("FAIL feed_accept: accepted %0d words, expected %0d", k, W);
      end
   endtask

`ifdef NN_LOAD_CHECKSUM_EN
   task automatic feed_cs(input logic [15:0] cs);
      int b;
      b = 0;
      s_valid = 1'b1;
      s_data = cs;
      #1;
      while (!s_ready && b < 20) begin
         @(negedge clk);
         #1;
         b++;
      end
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0;
      checks++;
      if (b >= 20) begin
         errors++;
         $display("FAIL checksum_ready: s_ready never rose, waited %0d cycles (limit 20)", b);
      end
   endtask
`endif

   task automatic run_and_check(input string name, input bit gaps, input int start_k,
                                input logic [15:0] cs);
      int k;
      int s;
      int r;
      int c;
      int b;
      bit exp_err;
      exp_err = 1'b0;
`ifdef NN_LOAD_CHECKSUM_EN
      exp_err = (cs != 16'hC8A0);
`endif
      wr_n = 0;
      done_n = 0;
      pulse_start();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL %s busy_after_start: busy=%b expected 1", name, busy);
      end
      feed(gaps, -1, start_k, -1, k);
`ifdef NN_LOAD_CHECKSUM_EN
      feed_cs(cs);
`endif
      b = 0;
      while (!done && b < 10) begin
         @(negedge clk);
         b++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s done_seen: done=%b expected 1 within 10 cycles", name, done);
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL %s busy_in_done: busy=%b expected 1", name, busy);
      end
      checks++;
      if (err !== exp_err) begin
         errors++;
         $display("FAIL %s err_in_done: err=%b expected %b (cs %h)", name, err, exp_err, cs);
      end
      @(negedge clk);
      checks++;
      if ({busy, done, err} !== {2'b00, exp_err}) begin
         errors++;
         $display("FAIL %s after_done: busy/done/err=%b expected %b", name, {busy, done, err},
                  {2'b00, exp_err});
      end
      checks++;
      if (wr_n != W) begin
         errors++;
         $display("FAIL %s write_count: got %0d writes, expected %0d", name, wr_n, W);
      end
      for (int i = 0; i < wr_n && i < W; i++) begin
         exp_idx(i, s, r, c);
         checks++;
         if (log_sel[i] != s || log_row[i] != r || log_col[i] != c || log_dat[i] != i) begin
            errors++;
            $display("FAIL %s write[%0d]: sel/row/col/data=%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                     name, i, log_sel[i], log_row[i], log_col[i], log_dat[i], s, r, c, i);
         end
      end
      if (wr_n == W) begin
         if (!gaps) begin
            checks++;
            if (log_cyc[W-1] - log_cyc[0] != W - 1) begin
               errors++;
               $display("FAIL %s back_to_back: writes spanned %0d cycles, expected %0d", name,
                        log_cyc[W-1] - log_cyc[0], W - 1);
            end
         end
         checks++;
         if (done_n != 1 || done_cyc != log_cyc[W-1] + 1) begin
            errors++;
            $display("FAIL %s done_timing: %0d pulses at cycle %0d, expected 1 at cycle %0d",
                     name, done_n, done_cyc, log_cyc[W-1] + 1);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      s_valid = 1'b0;
      s_data = '0;
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({wr_en, wr_sel, wr_row, wr_col, wr_data, busy, done, err, s_ready} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: wr_en=%b sel=%0d row=%0d col=%0d data=%h busy=%b done=%b err=%b s_ready=%b, expected all 0",
                  wr_en, wr_sel, wr_row, wr_col, wr_data, busy, done, err, s_ready);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      s_valid = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (wr_n != 0 || busy !== 1'b0 || s_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: writes=%0d busy=%b s_ready=%b expected 0/0/0", wr_n, busy, s_ready);
      end
      s_valid = 1'b0;
   endtask

   task automatic test_index_spots();
      int idx [0:7];
      int es  [0:7];
      int er  [0:7];
      int ec  [0:7];
      idx = '{0, 15, 16, 32, 49, 303, 319, 320};
      es  = '{0,  0,  1,  2,  2,   3,   4,   5};
      er  = '{0, 15,  0,  0,  1,  15,   0,   0};
      ec  = '{0,  0,  0,  0,  1,   0,  15,   0};
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (log_sel[idx[i]] != es[i] || log_row[idx[i]] != er[i] || log_col[idx[i]] != ec[i]) begin
            errors++;
            $display("FAIL index_spot k=%0d: sel/row/col=%0d/%0d/%0d expected %0d/%0d/%0d", idx[i],
                     log_sel[idx[i]], log_row[idx[i]], log_col[idx[i]], es[i], er[i], ec[i]);
         end
      end
   endtask

   task automatic test_abort();
      int k;
      // start and abort together in IDLE: stays idle
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || s_ready !== 1'b0) begin
         errors++;
         $display("FAIL abort_start_idle: busy=%b s_ready=%b expected 0/0", busy, s_ready);
      end
      wr_n = 0;
      done_n = 0;
      pulse_start();
      feed(1'b0, 100, -1, -1, k);
      checks++;
      if (busy !== 1'b0 || wr_en !== 1'b0 || s_ready !== 1'b0) begin
         errors++;
         $display("FAIL abort_next_cycle: busy=%b wr_en=%b s_ready=%b expected 0/0/0", busy, wr_en, s_ready);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (wr_n != 100 || done_n != 0) begin
         errors++;
         $display("FAIL abort_writes: writes=%0d done pulses=%0d expected 100/0", wr_n, done_n);
      end
      checks++;
      if (wr_n >= 100 && log_dat[99] != 99) begin
         errors++;
         $display("FAIL abort_last_write: data=%0d expected 99", log_dat[99]);
      end
      run_and_check("after_abort", 1'b0, -1, 16'hC8A0);
   endtask

   task automatic test_reset_midload();
      int k;
      wr_n = 0;
      done_n = 0;
      pulse_start();
      feed(1'b0, -1, -1, 200, k);
      #1;
      checks++;
      if ({wr_en, wr_sel, wr_row, wr_col, wr_data, busy, done, err, s_ready} !== '0) begin
         errors++;
         $display("FAIL midload_reset_outputs: wr_en=%b sel=%0d row=%0d col=%0d data=%h busy=%b s_ready=%b expected all 0",
                  wr_en, wr_sel, wr_row, wr_col, wr_data, busy, s_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (wr_n != 200 || done_n != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midload_reset_idle: writes=%0d done=%0d busy=%b expected 200/0/0", wr_n, done_n, busy);
      end
   endtask

`ifdef NN_LOAD_CHECKSUM_EN
   task automatic test_checksum_bad();
      run_and_check("cs_bad", 1'b0, -1, 16'hC8A1);
      repeat (3) @(negedge clk);
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL cs_err_held: err=%b expected 1", err);
      end
      pulse_start();
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL cs_err_cleared: err=%b expected 0", err);
      end
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL cs_cleanup_abort: busy=%b expected 0", busy);
      end
   endtask
`endif

   initial begin
      test_reset();
      run_and_check("full", 1'b0, -1, 16'hC8A0);
      test_index_spots();
      run_and_check("gaps", 1'b1, -1, 16'hC8A0);
      test_abort();
      run_and_check("start_ignored", 1'b0, 50, 16'hC8A0);
      test_reset_midload();
`ifdef NN_LOAD_CHECKSUM_EN
      test_checksum_bad();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
